// File: rtl/ddr3_wr_burst_pkg.sv
// ddr3_wr_burst_pkg: MIG command encodings and burst FSM states shared by the DDR3_RW datapath
package ddr3_wr_burst_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
endpackage

// File: rtl/ddr3_wr_burst_if.sv
// ddr3_wr_burst_if: user-side burst handshake plus MIG app command/write-data bus
interface ddr3_wr_burst_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28
);
    logic                    wr_burst_start;
    logic [ADDR_WIDTH-1:0]   wr_burst_len;
    logic [ADDR_WIDTH-1:0]   wr_burst_addr;
    logic [DATA_WIDTH-1:0]   wr_burst_data;
    logic                    wr_burst_data_req;
    logic                    wr_burst_busy;
    logic                    wr_burst_done;
    logic                    app_en;
    logic                    app_rdy;
    logic [2:0]              app_cmd;
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_rdy;
    modport master (
        input  wr_burst_start, wr_burst_len, wr_burst_addr, wr_burst_data, app_rdy, app_wdf_rdy,
        output wr_burst_data_req, wr_burst_busy, wr_burst_done, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
    modport slave (
        output wr_burst_start, wr_burst_len, wr_burst_addr, wr_burst_data, app_rdy, app_wdf_rdy,
        input  wr_burst_data_req, wr_burst_busy, wr_burst_done, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/ddr3_wr_burst.sv
// ddr3_wr_burst: drains a FWFT FIFO into MIG as paired write-data beats and WRITE commands,
// keeping data at or ahead of commands by at most MAX_LEAD beats.
module ddr3_wr_burst
    import ddr3_wr_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int ADDR_STEP  = 8,
    parameter int MAX_LEAD   = 2
) (
    input logic              clk,
    input logic              rst_n,
    ddr3_wr_burst_if.master  bus
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] len_q, addr_q, cmd_cnt, dat_cnt, cmd_nx, dat_nx;
    logic                  busy_q, done_q, wren, en, dat_hs, cmd_hs;
    // Enables depend only on registered state so rdy never feeds back into valid
    assign wren   = state == WRITE && dat_cnt < len_q && (dat_cnt - cmd_cnt) < ADDR_WIDTH'(MAX_LEAD);
    assign en     = state == WRITE && cmd_cnt < len_q && cmd_cnt < dat_cnt;
    assign dat_hs = wren && bus.app_wdf_rdy;
    assign cmd_hs = en && bus.app_rdy;
    assign dat_nx = dat_hs ? dat_cnt + 1'b1 : dat_cnt;
    assign cmd_nx = cmd_hs ? cmd_cnt + 1'b1 : cmd_cnt;
    assign bus.wr_burst_data_req = dat_hs;
    assign bus.wr_burst_busy     = busy_q;
    assign bus.wr_burst_done     = done_q;
    assign bus.app_en            = en;
    assign bus.app_cmd           = CMD_WRITE;
    assign bus.app_addr          = addr_q;
    assign bus.app_wdf_wren      = wren;
    assign bus.app_wdf_end       = wren;
    assign bus.app_wdf_data      = bus.wr_burst_data;
    assign bus.app_wdf_mask      = {(DATA_WIDTH/8){1'b0}};
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            cmd_cnt <= '0;
            dat_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.wr_burst_start && bus.wr_burst_len != '0) begin
                    state   <= WRITE;
                    busy_q  <= 1'b1;
                    len_q   <= bus.wr_burst_len;
                    addr_q  <= bus.wr_burst_addr;
                    cmd_cnt <= '0;
                    dat_cnt <= '0;
                end
                WRITE: begin
                    dat_cnt <= dat_nx;
                    cmd_cnt <= cmd_nx;
                    if (cmd_hs) addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                    if (dat_nx == len_q && cmd_nx == len_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_wr_burst.sv
// tb_ddr3_wr_burst: directed bursts with hand-computed addresses, beats and done timing.
module tb_ddr3_wr_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr3_wr_burst_if #(.DATA_WIDTH(128), .ADDR_WIDTH(28)) bus();
    ddr3_wr_burst #(.DATA_WIDTH(128), .ADDR_WIDTH(28), .ADDR_STEP(8), .MAX_LEAD(2)) dut (
        .clk(clk), .rst_n(rst), .bus(bus.master)
    );

    logic [127:0] fifo [16];
    logic [127:0] dlog [$];
    logic [27:0]  alog [$];
    int n_tests = 0, n_fail = 0;
    int head, cyc, n_busy, first_busy, n_done, done_cyc, n_req, ndat, ncmd, en_viol, max_lead;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        dlog.delete(); alog.delete();
        head = 0; cyc = -1; n_busy = 0; first_busy = 0; n_done = 0; done_cyc = 0;
        n_req = 0; ndat = 0; ncmd = 0; en_viol = 0; max_lead = 0;
    endtask

    // One clock: apply rdy + FIFO head, observe at negedge, return #1 after the next posedge
    task automatic step(input logic ar, input logic wr);
        logic adv;
        bus.app_rdy = ar;
        bus.app_wdf_rdy = wr;
        bus.wr_burst_data = fifo[head % 16];
        @(negedge clk);
        cyc++;
        adv = bus.wr_burst_data_req;
        if (bus.wr_burst_busy) begin n_busy++; if (first_busy == 0) first_busy = cyc; end
        if (bus.wr_burst_done) begin n_done++; done_cyc = cyc; end
        if (bus.app_en && ncmd == ndat) en_viol++;
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin dlog.push_back(bus.app_wdf_data); ndat++; end
        if (bus.app_en && bus.app_rdy) begin alog.push_back(bus.app_addr); ncmd++; end
        if (bus.wr_burst_data_req) n_req++;
        if (ndat - ncmd > max_lead) max_lead = ndat - ncmd;
        @(posedge clk);
        #1;
        if (adv) head++;
    endtask

    task automatic start_burst(input logic [27:0] len, input logic [27:0] addr);
        clear();
        bus.wr_burst_start = 1'b1;
        bus.wr_burst_len = len;
        bus.wr_burst_addr = addr;
        step(1'b1, 1'b1);
        bus.wr_burst_start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {127'd0, bus.wr_burst_busy}, 128'd0);
        check({tag, "_done"}, {127'd0, bus.wr_burst_done}, 128'd0);
        check({tag, "_en"}, {127'd0, bus.app_en}, 128'd0);
        check({tag, "_wren"}, {127'd0, bus.app_wdf_wren}, 128'd0);
        check({tag, "_req"}, {127'd0, bus.wr_burst_data_req}, 128'd0);
        check({tag, "_addr"}, {100'd0, bus.app_addr}, 128'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) fifo[i] = {32'hD0D0_0000 + i, 96'h0123_4567_89AB_CDEF_0000_0000 + 96'(i)};
        bus.wr_burst_start = 1'b0;
        bus.wr_burst_len = '0;
        bus.wr_burst_addr = '0;
        clear();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_idle("reset");
        check("reset_mask", {112'd0, bus.app_wdf_mask}, 128'd0);
        rst = 1'b0;

        start_burst(28'd4, 28'h100);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1);
        check("b2b_ncmd", 128'(alog.size()), 128'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++) check($sformatf("b2b_addr%0d", i), {100'd0, alog[i]}, 128'(28'h100 + 28'(8 * i)));
        for (int i = 0; i < 4 && i < dlog.size(); i++) check($sformatf("b2b_data%0d", i), dlog[i], fifo[i]);
        check("b2b_req", 128'(n_req), 128'd4);
        check("b2b_done_cyc", 128'(done_cyc), 128'd6);
        check("b2b_ndone", 128'(n_done), 128'd1);
        check("b2b_busy_cycles", 128'(n_busy), 128'd5);
        check("b2b_busy_first", 128'(first_busy), 128'd1);
        check("b2b_cmd", {125'd0, bus.app_cmd}, 128'd0);

        start_burst(28'd4, 28'h300);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
        check("cbp_beats", 128'(dlog.size()), 128'd2);
        check("cbp_cmds", 128'(alog.size()), 128'd0);
        check("cbp_wren", {127'd0, bus.app_wdf_wren}, 128'd0);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b1);
        check("cbp_ncmd", 128'(alog.size()), 128'd4);
        check("cbp_nbeat", 128'(dlog.size()), 128'd4);
        check("cbp_lead", 128'(max_lead), 128'd2);
        check("cbp_ndone", 128'(n_done), 128'd1);
        if (alog.size() == 4) check("cbp_last_addr", {100'd0, alog[3]}, 128'h318);

        start_burst(28'd3, 28'h0);
        for (int c = 0; c < 12; c++) step(1'b1, 1'(c % 2 == 0));
        check("dbp_en_viol", 128'(en_viol), 128'd0);
        check("dbp_ncmd", 128'(alog.size()), 128'd3);
        check("dbp_nbeat", 128'(dlog.size()), 128'd3);
        check("dbp_ndone", 128'(n_done), 128'd1);
        if (dlog.size() == 3) check("dbp_data2", dlog[2], fifo[2]);

        start_burst(28'd0, 28'h40);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
        check("zero_busy", 128'(n_busy), 128'd0);
        check("zero_done", 128'(n_done), 128'd0);

        start_burst(28'd3, 28'h200);
        step(1'b1, 1'b1);
        bus.wr_burst_start = 1'b1;
        bus.wr_burst_len = 28'd9;
        bus.wr_burst_addr = 28'h500;
        step(1'b1, 1'b1);
        bus.wr_burst_start = 1'b0;
        for (int c = 0; c < 12; c++) step(1'b1, 1'b1);
        check("mid_ncmd", 128'(alog.size()), 128'd3);
        check("mid_nbeat", 128'(dlog.size()), 128'd3);
        check("mid_ndone", 128'(n_done), 128'd1);
        if (alog.size() == 3) check("mid_last_addr", {100'd0, alog[2]}, 128'h210);

        start_burst(28'd4, 28'h80);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("rst_beats_before", 128'(dlog.size()), 128'd2);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        check_idle("rst_mid");
        n_done = 0;
        for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
        check("rst_no_done", 128'(n_done), 128'd0);
        start_burst(28'd2, 28'h40);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
        check("rst_fresh_ndone", 128'(n_done), 128'd1);
        check("rst_fresh_done_cyc", 128'(done_cyc), 128'd4);
        if (alog.size() == 2) check("rst_fresh_addr1", {100'd0, alog[1]}, 128'h48);

        start_burst(28'd2, 28'hFFFFFF8);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
        check("wrap_ncmd", 128'(alog.size()), 128'd2);
        if (alog.size() == 2) begin
            check("wrap_addr0", {100'd0, alog[0]}, 128'hFFFFFF8);
            check("wrap_addr1", {100'd0, alog[1]}, 128'h0);
        end
        check("wrap_ndone", 128'(n_done), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr3_wr_burst.md
# ddr3_wr_burst

Burst write controller between the write-side FIFO and the MIG user interface in the DDR3_RW datapath. On a start pulse it latches a length and base address, pulls that many DATA_WIDTH words out of a first-word-fall-through FIFO, and pushes them to MIG as paired write-data beats (app_wdf_*) and WRITE commands (app_en/app_addr). Data always leads or matches commands, within a bounded lead. It is the write-direction counterpart of the existing DDR3 burst reader and shares its user-side handshake style: start, busy, done.

## Interface
- DATA_WIDTH, 128, MIG app data width
- ADDR_WIDTH, 28, MIG app address and length counter width
- ADDR_STEP, 8, app_addr increment per command (BL8)
- MAX_LEAD, 2, maximum accepted data beats ahead of accepted commands (≥1)

Ports:
- clk  in  1  user clock (MIG ui_clk)
- rst_n  in  1  reset; synchronous, active-high (1 = reset)
- wr_burst_start  in  1  one-cycle start pulse
- wr_burst_len  in  ADDR_WIDTH  number of words/commands; sampled with start
- wr_burst_addr  in  ADDR_WIDTH  first app_addr; sampled with start
- wr_burst_data  in  DATA_WIDTH  FWFT FIFO head word
- wr_burst_data_req  out  1  FIFO read strobe; head consumed this cycle
- wr_burst_busy  out  1  burst in progress
- wr_burst_done  out  1  one-cycle pulse, all data and commands accepted
- app_en  out  1  command valid
- app_rdy  in  1  MIG command accept
- app_cmd  out  3  constant 3'b000 (WRITE)
- app_addr  out  ADDR_WIDTH  command address
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat per BL8 word)
- app_wdf_data  out  DATA_WIDTH  = wr_burst_data
- app_wdf_mask  out  DATA_WIDTH/8  constant 0
- app_wdf_rdy  in  1  MIG write-data accept

## Operation
- States: IDLE, WRITE, DONE. Registers: len_q, app_addr, cmd_cnt, dat_cnt (all ADDR_WIDTH).
- IDLE: start with len≠0 → WRITE. Same edge: len_q←len, app_addr←addr, cmd_cnt←0, dat_cnt←0. Start with len=0 is ignored, with no busy and no done.
- Start outside IDLE is ignored. Latched values do not change.
- WRITE:
  - app_wdf_wren = (dat_cnt<len_q) && (dat_cnt−cmd_cnt < MAX_LEAD).
  - app_en = (cmd_cnt<len_q) && (cmd_cnt<dat_cnt). A command is never issued before its data beat.
  - Data handshake wren&&wdf_rdy: dat_cnt+1, wr_burst_data_req=1 (combinational, same cycle).
  - Command handshake app_en&&app_rdy: cmd_cnt+1, app_addr+=ADDR_STEP (wraps modulo 2^ADDR_WIDTH).
  - Both handshakes may occur in the same cycle.
  - When counts after update both equal len_q → DONE.
- DONE: wr_burst_done=1, busy=0, app_en=wren=0; next cycle → IDLE.
- busy=1 exactly in WRITE.
- app_en, app_wdf_wren and data_req decode from registered state/counters plus the rdy inputs only. There is no combinational path from rdy into app_en or wren.
- Reset (any state): state IDLE, counters 0, app_addr 0, len_q 0. All outputs 0 except app_wdf_data, which follows the input. A burst in flight is abandoned and no done is produced.

## Timing
- Start at edge T: busy and wren high from T+1 (cycle 1). With wdf_rdy=1, app_en is first high in cycle 2.
- Full throughput, both rdy=1: one data beat and one command per cycle. The last command is accepted in cycle len+1, and done is high in cycle len+2.
- Done lasts one cycle. The next start is accepted in the IDLE cycle after DONE (earliest T+len+3).
- Stall on app_rdy=0: data runs ahead by at most MAX_LEAD, then wren drops until a command is accepted.
- Stall on wdf_rdy=0: app_en drops once cmd_cnt==dat_cnt.

## Structure
- The shared DDR3_RW package holds the MIG command encodings CMD_WRITE=3'b000 and CMD_READ=3'b001, and the state enum.
- Single module with no sub-modules. The counter/compare logic is too small to split out.

## Test plan
- Back-to-back burst: len=4, addr=0x100, both rdy=1, FIFO words D0..D3. Expected: app_addr 0x100, 0x108, 0x110, 0x118; wdf_data D0..D3 in order; 4 data_req; done pulse in cycle 6; busy high cycles 1–5.
- Command backpressure: app_rdy=0 for 5 cycles, len=4. Expected: exactly MAX_LEAD=2 beats accepted, then wren low; on release all 4 commands issue and done fires once.
- Data backpressure: wdf_rdy toggles 1,0,1,0, len=3. Expected: app_en never high while cmd_cnt==dat_cnt; 3 commands and 3 beats; single done.
- Ignored starts: start with len=0 gives no busy/done. Start pulse mid-burst with len=9 → len_q unchanged, the burst completes with the original length.
- Reset mid-burst: rst_n=1 after 2 beats. Expected: next cycle all outputs 0, state IDLE, no done; a fresh len=2 burst then completes normally.
- Address wrap: ADDR_WIDTH=28, addr=0xFFFFFF8, len=2. Expected: app_addr 0xFFFFFF8 then 0x0000000.
